// File: rtl/wb_arbiter.sv
// wb_arbiter: collects completions from the execute FUs (ALU=0, MEM=1, BR=2), buffers each FU in
// a small FIFO and serializes them round-robin onto one registered writeback stream. A recovery
// pulse squashes queued, incoming and registered packets younger than the mispredicted branch.
//
// Ports:
//   clk_i              clock, all state on rising edge
//   rst_i              synchronous reset, active-low
//   fu_valid_i         per-FU packet valid
//   fu_packet_i        per-FU completion packet
//   fu_ready_o         per-FU FIFO has space (function of FIFO count only)
//   wb_valid_o         output register holds a packet
//   wb_packet_o        registered writeback packet (stale when wb_valid_o=0)
//   wb_ready_i         downstream accepts
//   recover_i          one-cycle recovery pulse
//   recover_rob_tag_i  ROB tag of the mispredicted branch
//   rob_head_i         oldest in-flight ROB index

package buffer_pkgs;
    typedef struct packed {
        logic        completed;
        logic [3:0]  rob_tag;
        logic [4:0]  rd;
        logic [31:0] value;
    } wb_packet_t;
endpackage

module wb_arbiter
    import buffer_pkgs::*;
#(
    parameter int unsigned ROB_DEPTH  = 16,
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned NUM_FU     = 3
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [NUM_FU-1:0]            fu_valid_i,
    input  wb_packet_t                   fu_packet_i [NUM_FU],
    output logic [NUM_FU-1:0]            fu_ready_o,
    output logic                         wb_valid_o,
    output wb_packet_t                   wb_packet_o,
    input  logic                         wb_ready_i,
    input  logic                         recover_i,
    input  logic [3:0]                   recover_rob_tag_i,
    input  logic [$clog2(ROB_DEPTH)-1:0] rob_head_i
);

    localparam int unsigned TagW = $clog2(ROB_DEPTH);
    localparam int unsigned FuW  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
    localparam int unsigned IdxW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CntW-1:0] DepthC = CntW'(FIFO_DEPTH);

    wb_packet_t      mem_q   [NUM_FU][FIFO_DEPTH];
    wb_packet_t      mem_d   [NUM_FU][FIFO_DEPTH];
    logic [CntW-1:0] count_q [NUM_FU];
    logic [CntW-1:0] count_d [NUM_FU];
    logic [FuW-1:0]  rr_ptr_q, rr_ptr_d;
    logic            wb_valid_q, wb_valid_d;
    wb_packet_t      wb_packet_q, wb_packet_d;

    logic            ld;
    logic            grant_valid;
    logic [FuW-1:0]  grant_idx;

    // Age relative to the ROB head; modular subtraction handles wrap.
    function automatic logic [TagW-1:0] age_of(input logic [TagW-1:0] tag,
                                               input logic [TagW-1:0] head);
        return tag - head;
    endfunction

    function automatic logic is_younger(input logic [3:0] tag, input logic [3:0] rtag,
                                        input logic [TagW-1:0] head);
        return age_of(TagW'(tag), head) > age_of(TagW'(rtag), head);
    endfunction

    always_comb begin
        for (int i = 0; i < NUM_FU; i++) begin
            fu_ready_o[i] = count_q[i] < DepthC;
        end
    end

    assign wb_valid_o  = wb_valid_q;
    assign wb_packet_o = wb_packet_q;

    // Round-robin grant starting at rr_ptr; suppressed during recovery or when the output holds.
    always_comb begin
        int unsigned idx;
        ld          = !wb_valid_q || wb_ready_i;
        grant_valid = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        for (int unsigned k = 0; k < NUM_FU; k++) begin
            idx = (int'(rr_ptr_q) + k) % NUM_FU;
            if (!grant_valid && (count_q[FuW'(idx)] != '0)) begin
                grant_valid = 1'b1;
                grant_idx   = FuW'(idx);
            end
        end
        if (recover_i || !ld) begin
            grant_valid = 1'b0;
        end
    end

    // FIFO next state: drop popped head and squashed entries, compact, then append the push.
    always_comb begin
        int unsigned w;
        logic        pop;
        logic        keep;
        logic        push;
        mem_d = mem_q;
        w     = 0;
        pop   = 1'b0;
        keep  = 1'b0;
        push  = 1'b0;
        for (int i = 0; i < NUM_FU; i++) begin
            w   = 0;
            pop = grant_valid && (grant_idx == FuW'(i));
            for (int j = 0; j < FIFO_DEPTH; j++) begin
                keep = (CntW'(j) < count_q[i])
                    && !(pop && (j == 0))
                    && !(recover_i && is_younger(mem_q[i][j].rob_tag, recover_rob_tag_i,
                                                 rob_head_i));
                if (keep) begin
                    mem_d[i][IdxW'(w)] = mem_q[i][j];
                    w = w + 1;
                end
            end
            // Packets with completed=0 are accepted but not stored.
            push = fu_valid_i[i] && fu_ready_o[i] && fu_packet_i[i].completed
                && !(recover_i && is_younger(fu_packet_i[i].rob_tag, recover_rob_tag_i,
                                             rob_head_i));
            if (push && (w < FIFO_DEPTH)) begin
                mem_d[i][IdxW'(w)] = fu_packet_i[i];
                w = w + 1;
            end
            count_d[i] = CntW'(w);
        end
    end

    always_comb begin
        wb_packet_d = wb_packet_q;
        rr_ptr_d    = rr_ptr_q;
        if (recover_i) begin
            // No grant this cycle: a loaded register empties, a held one survives only if older.
            wb_valid_d = !ld && wb_valid_q
                && !is_younger(wb_packet_q.rob_tag, recover_rob_tag_i, rob_head_i);
        end else if (ld) begin
            wb_valid_d = grant_valid;
        end else begin
            wb_valid_d = wb_valid_q;
        end
        if (grant_valid) begin
            wb_packet_d = mem_q[grant_idx][0];
            rr_ptr_d    = (grant_idx == FuW'(NUM_FU - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            for (int i = 0; i < NUM_FU; i++) begin
                count_q[i] <= '0;
                for (int j = 0; j < FIFO_DEPTH; j++) begin
                    mem_q[i][j] <= '0;
                end
            end
            rr_ptr_q    <= '0;
            wb_valid_q  <= 1'b0;
            wb_packet_q <= '0;
        end else begin
            mem_q       <= mem_d;
            count_q     <= count_d;
            rr_ptr_q    <= rr_ptr_d;
            wb_valid_q  <= wb_valid_d;
            wb_packet_q <= wb_packet_d;
        end
    end

endmodule
